serial_read_sequencer: RTL
==========================

Name: serial_read_sequencer

Overview:
- Control stage directly downstream of the serial read buffer (shift-in primitive with start/read_count/data_out/done_sig).
- While a bus frame is active (e.g. synchronised chip-select), it re-arms the read buffer word after word and stages each completed word.
- Completed words are pushed into a small FIFO with a last-word marker for the MITM manipulation logic.
- Aborts cleanly if the frame ends mid-word.

Parameters:
- BUF_SIZE, 8, maximum word width; equals the read buffer's BUF_SIZE.
- COUNT_SIZE, $clog2(BUF_SIZE+1), width of bit-count fields.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_active  in  1  level; high while a bus frame is in progress; already synchronised.
- word_bits  in  COUNT_SIZE  bits per word; sampled at each buffer arm; legal range 1..BUF_SIZE.
- buf_start  out  1  one-cycle pulse to the read buffer's start input.
- buf_read_count  out  COUNT_SIZE  to the buffer's read_count; held stable from the arm cycle until done.
- buf_abort  out  1  one-cycle pulse; integration ORs it with rst onto the buffer's rst.
- buf_data  in  BUF_SIZE  buffer data_out.
- buf_done  in  1  buffer done_sig; level, high while the buffer is idle or finished.
- out_data  out  BUF_SIZE  FIFO head word, right-aligned; unused MSBs are zero.
- out_last  out  1  FIFO head is the final complete word of its frame.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head when out_valid && out_ready.
- overflow  out  1  sticky; set when a push is dropped because the FIFO is full; cleared only by rst.
- partial_drop  out  1  one-cycle pulse when a frame ends with a word in progress.

Behaviour:
- Reset values: all outputs 0, FIFO empty, staging register empty, FSM in IDLE.
- FSM states:
  - IDLE: when frame_active=1, go to ARM.
  - ARM: assert buf_start for 1 cycle; latch word_bits into buf_read_count (0 is treated as 1, values above BUF_SIZE are clamped to BUF_SIZE); go to SETTLE.
  - SETTLE: one-cycle wait so the buffer can drop done; go to WAIT.
  - WAIT:
    - On buf_done=1 with frame_active=1: capture buf_data masked to buf_read_count bits, go to CAPTURE.
    - On frame_active=0 (takes priority over buf_done in the same cycle): pulse buf_abort and partial_drop, go to FLUSH.
  - CAPTURE:
    - If the staging register is full, push it with last=0.
    - Load the new word into staging.
    - If frame_active=1 go to ARM, else go to FLUSH.
  - FLUSH: if staging is full, push it with last=1 and empty it; go to IDLE.
- Re-arm latency: ARM is entered 1 cycle after CAPTURE, so back-to-back words need at least 4 sys_clk between the done edge and the next bit's read_sig.
- Push and pop:
  - A push and a pop may happen in the same cycle; simultaneous push and pop when full succeeds with no overflow.
  - A push when full, with no pop that cycle, is dropped and sets overflow.
- A frame with zero complete words pushes nothing.
- rst mid-frame: everything clears immediately; a new frame starts only after frame_active has been seen 0 and then 1 again, via a re-arm guard flag.

Decomposition:
- Shared package serial_pkg holds: FSM state encoding (IDLE, ARM, SETTLE, WAIT, CAPTURE, FLUSH), the COUNT_SIZE derivation, and the clamp rule for word_bits.
- One sub-module, sync_fifo:
  - Parameters WIDTH = BUF_SIZE+1 and DEPTH.
  - Pointer wrap by extra MSB.
  - Ports push, pop, din, dout, full, empty.

Test Plan:
- Frame of 3 words, word_bits=8, data 0x3A, 0xC5, 0x01, out_ready=1 -> FIFO outputs 0x3A/last0, 0xC5/last0, 0x01/last1; overflow=0; exactly 3 buf_start pulses.
- word_bits=6, sent 6'o52 -> out_data=0x2A with bits[7:6]=0, last=1; word_bits=0 -> reads 1 bit.
- Frame ends after 3 of 8 bits of the 2nd word -> buf_abort and partial_drop pulse once; only word 1 appears, with last=1.
- out_ready=0, FIFO_DEPTH=4, frame of 6 words -> 4 entries held; overflow=1 after the 5th push; head still holds word 1.
- FIFO full, out_ready=1 during a push -> push and pop in the same cycle; no overflow; order preserved.
- rst asserted 3333 ns into a word with frame_active held 1 -> all outputs 0 within the cycle; no buf_start until frame_active toggles 0 then 1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial read sequencer: FSM encoding,
// bit-count width derivation and the word_bits clamp rule.
package serial_pkg;

  localparam int unsigned BUF_SIZE_DEF   = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SETTLE,
    WAIT,
    CAPTURE,
    FLUSH
  } state_e;

  function automatic int unsigned count_size(input int unsigned buf_size);
    return $clog2(buf_size + 1);
  endfunction

  // A zero request still reads one bit; oversize requests saturate at the buffer width.
  function automatic int unsigned clamp_bits(input int unsigned bits, input int unsigned max_bits);
    if (bits == 0) return 1;
    if (bits > max_bits) return max_bits;
    return bits;
  endfunction

endpackage

// File: rtl/serial_read_sequencer_fifo.sv
// Small synchronous FIFO; pointers carry an extra MSB to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is accepted when the same cycle pops the head.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/serial_read_sequencer.sv
// Re-arms the serial read buffer word after word during a frame, stages each
// completed word and pushes it into an output FIFO with a last-word marker.
module serial_read_sequencer
  import serial_pkg::*;
#(
  parameter int unsigned BUF_SIZE   = BUF_SIZE_DEF,
  parameter int unsigned COUNT_SIZE = count_size(BUF_SIZE),
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  frame_active,
  input  logic [COUNT_SIZE-1:0] word_bits,
  output logic                  buf_start,
  output logic [COUNT_SIZE-1:0] buf_read_count,
  output logic                  buf_abort,
  input  logic [BUF_SIZE-1:0]   buf_data,
  input  logic                  buf_done,
  output logic [BUF_SIZE-1:0]   out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  partial_drop
);

  state_e                state_q, state_d;
  logic [COUNT_SIZE-1:0] rc_q, rc_d;
  logic [BUF_SIZE-1:0]   cap_q, cap_d;
  logic [BUF_SIZE-1:0]   stage_q, stage_d;
  logic                  stage_full_q, stage_full_d;
  logic                  start_q, start_d;
  logic                  abort_q, abort_d;
  logic                  pdrop_q, pdrop_d;
  logic                  ovf_q, ovf_d;
  logic                  rearm_ok_q, rearm_ok_d;
  logic [BUF_SIZE-1:0]   cap_mask;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BUF_SIZE:0]     fifo_din, fifo_dout;

  assign fifo_pop = !fifo_empty && out_ready;

  always_comb begin
    for (int i = 0; i < BUF_SIZE; i++) begin
      cap_mask[i] = (32'(rc_q) > 32'(i));
    end
  end

  // Next-state, staging and FIFO-push decisions.
  always_comb begin
    state_d      = state_q;
    rc_d         = rc_q;
    cap_d        = cap_q;
    stage_d      = stage_q;
    stage_full_d = stage_full_q;
    abort_d      = 1'b0;
    pdrop_d      = 1'b0;
    fifo_push    = 1'b0;
    fifo_din     = '0;
    // After reset a frame may only start once frame_active has been seen low.
    rearm_ok_d   = rearm_ok_q || !frame_active;

    case (state_q)
      IDLE:   if (frame_active && rearm_ok_q) state_d = ARM;
      ARM:    state_d = SETTLE;
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (!frame_active) begin
          abort_d = 1'b1;
          pdrop_d = 1'b1;
          state_d = FLUSH;
        end else if (buf_done) begin
          cap_d   = buf_data & cap_mask;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (stage_full_q) begin
          fifo_push = 1'b1;
          fifo_din  = {1'b0, stage_q};
        end
        stage_d      = cap_q;
        stage_full_d = 1'b1;
        state_d      = frame_active ? ARM : FLUSH;
      end
      FLUSH: begin
        if (stage_full_q) begin
          fifo_push    = 1'b1;
          fifo_din     = {1'b1, stage_q};
          stage_full_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == ARM);
    if (state_d == ARM) begin
      rc_d = COUNT_SIZE'(clamp_bits(32'(word_bits), BUF_SIZE));
    end
    ovf_d = ovf_q || (fifo_push && fifo_full && !fifo_pop);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rc_q         <= '0;
      cap_q        <= '0;
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      pdrop_q      <= 1'b0;
      ovf_q        <= 1'b0;
      rearm_ok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rc_q         <= rc_d;
      cap_q        <= cap_d;
      stage_q      <= stage_d;
      stage_full_q <= stage_full_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      pdrop_q      <= pdrop_d;
      ovf_q        <= ovf_d;
      rearm_ok_q   <= rearm_ok_d;
    end
  end

  sync_fifo #(
    .WIDTH (BUF_SIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign buf_start      = start_q;
  assign buf_read_count = rc_q;
  assign buf_abort      = abort_q;
  assign partial_drop   = pdrop_q;
  assign overflow       = ovf_q;
  assign out_data       = fifo_dout[BUF_SIZE-1:0];
  assign out_last       = fifo_dout[BUF_SIZE];
  assign out_valid      = !fifo_empty;

endmodule
